// File: rtl/dmg_timer.sv
// DMG-style DIV/TIMA/TMA/TAC timer: free-running 16-bit system counter,
// falling-edge tick detection, delayed TIMA reload and a one-cycle timer IRQ.
`timescale 1ns/1ps

module dmg_timer (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        MREQ,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] A,
   input  logic [7:0]  D_IN,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   output logic        IRQ_TIMER
);

   typedef enum logic [1:0] {ST_IDLE, ST_OVF, ST_RELOAD} state_t;

   localparam logic [13:0] REG_PAGE = 14'h3FC1;   // 0xFF04..0xFF07 >> 2

   logic [15:0] sys_q, sys_d;
   logic [7:0]  tima_q, tma_q, tma_d;
   logic [2:0]  tac_q, tac_d;
   state_t      state_q;
   logic [1:0]  ovf_cnt_q;
   logic        irq_q;

   logic        wr_prev_q, wr_hit_q;
   logic [1:0]  wr_addr_q;
   logic [7:0]  wr_data_q;

   logic        wr_commit, wr_div, wr_tima, wr_tma, wr_tac;
   logic [3:0]  taps_now, taps_nxt;
   logic        tick_now, tick_nxt, tick_fall;
   logic        rd_sel;

   // A write lands on the edge where WR is first seen low again.
   assign wr_commit = wr_prev_q & ~WR & wr_hit_q;
   assign wr_div    = wr_commit & (wr_addr_q == 2'd0);
   assign wr_tima   = wr_commit & (wr_addr_q == 2'd1);
   assign wr_tma    = wr_commit & (wr_addr_q == 2'd2);
   assign wr_tac    = wr_commit & (wr_addr_q == 2'd3);

   always_comb begin
      sys_d = wr_div ? 16'h0000 : sys_q + 16'd1;
      tac_d = wr_tac ? wr_data_q[2:0] : tac_q;
      tma_d = wr_tma ? wr_data_q : tma_q;
   end

   // Tick is compared before and after this edge, so DIV/TAC writes that
   // pull the selected bit low are seen as falling edges too.
   assign taps_now  = {sys_q[7], sys_q[5], sys_q[3], sys_q[9]};
   assign taps_nxt  = {sys_d[7], sys_d[5], sys_d[3], sys_d[9]};
   assign tick_now  = tac_q[2] & taps_now[tac_q[1:0]];
   assign tick_nxt  = tac_d[2] & taps_nxt[tac_d[1:0]];
   assign tick_fall = tick_now & ~tick_nxt;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         sys_q     <= 16'h0000;
         tima_q    <= 8'h00;
         tma_q     <= 8'h00;
         tac_q     <= 3'b000;
         state_q   <= ST_IDLE;
         ovf_cnt_q <= 2'd0;
         irq_q     <= 1'b0;
         wr_prev_q <= 1'b0;
         wr_hit_q  <= 1'b0;
         wr_addr_q <= 2'd0;
         wr_data_q <= 8'h00;
      end else begin
         sys_q     <= sys_d;
         tac_q     <= tac_d;
         tma_q     <= tma_d;
         wr_prev_q <= WR;
         if (WR) begin
            wr_hit_q  <= MREQ & (A[15:2] == REG_PAGE);
            wr_addr_q <= A[1:0];
            wr_data_q <= D_IN;
         end
         irq_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (wr_tima) begin
                  tima_q <= wr_data_q;
               end else if (tick_fall) begin
                  if (tima_q == 8'hFF) begin
                     tima_q    <= 8'h00;
                     state_q   <= ST_OVF;
                     ovf_cnt_q <= 2'd0;
                  end else begin
                     tima_q <= tima_q + 8'd1;
                  end
               end
            end
            ST_OVF: begin
               if (wr_tima) begin
                  tima_q  <= wr_data_q;
                  state_q <= ST_IDLE;
               end else if (ovf_cnt_q == 2'd3) begin
                  tima_q  <= tma_d;
                  state_q <= ST_RELOAD;
                  irq_q   <= 1'b1;
               end else begin
                  ovf_cnt_q <= ovf_cnt_q + 2'd1;
                  if (tick_fall) tima_q <= tima_q + 8'd1;
               end
            end
            ST_RELOAD: begin
               // A TMA write landing here is forwarded; TIMA writes are dropped.
               tima_q  <= tma_d;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign IRQ_TIMER = irq_q;
   assign rd_sel    = nRESET & MREQ & RD & (A[15:2] == REG_PAGE);
   assign D_OE      = rd_sel;

   always_comb begin
      D_OUT = 8'h00;
      if (rd_sel) begin
         case (A[1:0])
            2'd0:    D_OUT = sys_q[15:8];
            2'd1:    D_OUT = tima_q;
            2'd2:    D_OUT = tma_q;
            default: D_OUT = {5'b11111, tac_q};
         endcase
      end
   end

endmodule

// File: tb/tb_dmg_timer.sv
// Scoreboard bench for dmg_timer: reads queue their expected byte, a monitor
// pops and compares whenever the timer drives the databus.
`timescale 1ns/1ps

module tb_dmg_timer;

   logic        CLK = 1'b0;
   logic        nRESET = 1'b0;
   logic        MREQ = 1'b0;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic [15:0] A = 16'h0000;
   logic [7:0]  D_IN = 8'h00;
   logic [7:0]  D_OUT;
   logic        D_OE;
   logic        IRQ_TIMER;

   int n_tests = 0;
   int n_fail  = 0;
   int irq_cycles = 0;
   int irq_base = 0;

   logic [7:0] exp_q[$];
   string      name_q[$];

   dmg_timer dut (
      .CLK(CLK), .nRESET(nRESET), .MREQ(MREQ), .RD(RD), .WR(WR),
      .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .IRQ_TIMER(IRQ_TIMER)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", nm, act);
      end
   endtask

   // Monitor: every databus drive consumes one scoreboard entry.
   always @(negedge CLK) begin
      if (D_OE === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read: D_OUT 0x%0h, expected no bus drive", D_OUT);
         end else begin
            check(name_q.pop_front(), {24'h0, D_OUT}, {24'h0, exp_q.pop_front()});
         end
      end
      if (IRQ_TIMER === 1'b1) irq_cycles++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      MREQ = 1'b1; RD = 1'b1; A = addr;
      step(1);
      MREQ = 1'b0; RD = 1'b0;
   endtask

   // Capture edge, then commit edge; returns just after the commit.
   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input logic mreq);
      MREQ = mreq; WR = 1'b1; A = addr; D_IN = data;
      step(1);
      MREQ = 1'b0; WR = 1'b0;
      step(1);
   endtask

   task automatic bus_idle_probe(input logic [15:0] addr, input string nm);
      MREQ = 1'b1; RD = 1'b1; A = addr;
      #1;
      check({nm, "_oe"}, {31'h0, D_OE}, 32'h0);
      check({nm, "_dout"}, {24'h0, D_OUT}, 32'h0);
      MREQ = 1'b0; RD = 1'b0;
   endtask

   // Restart SYS from zero and enable TAC; afterwards SYS == 2.
   task automatic arm(input logic [7:0] tima, input logic [7:0] tac);
      bus_write(16'hFF05, tima, 1'b1);
      bus_write(16'hFF04, 8'h00, 1'b1);
      bus_write(16'hFF07, tac, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Bus must stay quiet while held in reset.
      #2;
      bus_idle_probe(16'hFF05, "reset_read");
      step(2);
      nRESET = 1'b1;

      step(256);
      bus_read(16'hFF04, 8'h01, "div_after_256");
      bus_read(16'hFF07, 8'hF8, "tac_reset");
      bus_read(16'hFF05, 8'h00, "tima_reset");
      bus_read(16'hFF06, 8'h00, "tma_reset");

      // Ignored writes: MREQ low, address out of range.
      bus_write(16'hFF06, 8'hAA, 1'b0);
      bus_write(16'hFF08, 8'hBB, 1'b1);
      bus_read(16'hFF06, 8'h00, "tma_ignored_wr");
      bus_idle_probe(16'hFF08, "oor_read");

      // Overflow with reload from TMA and a single IRQ cycle.
      bus_write(16'hFF06, 8'h40, 1'b1);
      arm(8'hFE, 8'h05);
      irq_base = irq_cycles;
      step(14);
      bus_read(16'hFF05, 8'hFF, "ovf_tima_ff");
      step(15);
      bus_read(16'hFF05, 8'h00, "ovf_tima_00");
      step(3);
      bus_read(16'hFF05, 8'h40, "ovf_reload");
      step(4);
      check("ovf_irq_cycles", irq_cycles - irq_base, 32'd1);
      bus_write(16'hFF07, 8'h00, 1'b1);

      // TIMA write during OVF cycle 2 cancels reload and IRQ.
      arm(8'hFF, 8'h05);
      irq_base = irq_cycles;
      step(14);
      bus_write(16'hFF05, 8'h10, 1'b1);
      bus_read(16'hFF05, 8'h10, "cancel_tima");
      step(6);
      bus_read(16'hFF05, 8'h10, "cancel_tima_hold");
      check("cancel_irq_cycles", irq_cycles - irq_base, 32'd0);
      // Disabling TAC while SYS[3]=1 is itself a falling tick.
      bus_write(16'hFF07, 8'h00, 1'b1);
      bus_read(16'hFF05, 8'h11, "tac_write_tick");

      // DIV write while SYS[9]=1 yields exactly one increment.
      arm(8'h20, 8'h04);
      step(598);
      bus_write(16'hFF04, 8'h5A, 1'b1);
      bus_read(16'hFF04, 8'h00, "div_cleared");
      bus_read(16'hFF05, 8'h21, "div_write_tick");
      bus_write(16'hFF07, 8'h00, 1'b1);

      // TMA write committing in RELOAD is forwarded into TIMA.
      arm(8'hFF, 8'h05);
      irq_base = irq_cycles;
      step(17);
      bus_write(16'hFF06, 8'h77, 1'b1);
      bus_read(16'hFF05, 8'h77, "reload_tma_fwd");
      bus_read(16'hFF06, 8'h77, "reload_tma_reg");
      step(2);
      check("reload_tma_irq", irq_cycles - irq_base, 32'd1);
      bus_write(16'hFF07, 8'h00, 1'b1);

      // TIMA write committing in RELOAD is dropped.
      arm(8'hFF, 8'h05);
      irq_base = irq_cycles;
      step(17);
      bus_write(16'hFF05, 8'h55, 1'b1);
      bus_read(16'hFF05, 8'h77, "reload_tima_drop");
      step(2);
      check("reload_tima_irq", irq_cycles - irq_base, 32'd1);
      bus_write(16'hFF07, 8'h00, 1'b1);

      // TIMA write coinciding with a tick edge wins; counting resumes after.
      arm(8'h00, 8'h05);
      step(12);
      bus_write(16'hFF05, 8'h30, 1'b1);
      bus_read(16'hFF05, 8'h30, "write_beats_tick");
      step(15);
      bus_read(16'hFF05, 8'h31, "tick_after_write");
      bus_write(16'hFF07, 8'h00, 1'b1);

      // Reset in OVF cycle 2 clears everything and drops the IRQ.
      arm(8'hFF, 8'h05);
      irq_base = irq_cycles;
      step(15);
      nRESET = 1'b0;
      bus_idle_probe(16'hFF05, "mid_ovf_reset");
      step(3);
      nRESET = 1'b1;
      step(10);
      bus_read(16'hFF05, 8'h00, "rst_tima");
      bus_read(16'hFF06, 8'h00, "rst_tma");
      bus_read(16'hFF07, 8'hF8, "rst_tac");
      bus_read(16'hFF04, 8'h00, "rst_div");
      check("rst_irq_cycles", irq_cycles - irq_base, 32'd0);

      step(3);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
